multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle successor to the single-cycle ARM decoder; same op/funct/rd instruction fields, same control-signal family.
- Moore FSM sequences each instruction over 3–5 cycles and drives the shared-memory multicycle datapath.
- Parametrised ALU-control width adds EOR/MOV support; adds illegal-op trap, CMP shortcut and U-bit address subtraction.
- Sits between the instruction register/condition check and the datapath muxes.

Parameters:
- ALU_W, 2, ALU control width. 2 = ADD/SUB/AND/ORR; 3 also decodes EOR and MOV.
- CNT_W, 32, retired-instruction counter width (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op  in  2  instr[27:26]
- funct  in  6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S/L, [3]=U for memory
- rd  in  4  instr[15:12]
- cond_ex  in  1  condition pass from cond check; valid from DECODE onward
- pc_write  out  1  PC enable
- adr_src  out  1  0=PC, 1=ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  IR enable
- reg_write  out  1  register-file write enable
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  1  0=RegA, 1=PC
- alu_src_b  out  2  00=RegB, 01=ExtImm, 10=const 4
- imm_src  out  2  = op
- reg_src  out  2  [1]=(op==01), [0]=(op==10)
- alu_control  out  ALU_W  ALU operation
- flag_write  out  2  [1] NZ, [0] CV
- illegal  out  1  one-cycle pulse on undecodable instruction

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high. While reset=1: next state=FETCH and all enables (pc_write, ir_write, mem_write, reg_write, flag_write, illegal) are forced to 0. FETCH is the first active state after release.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR if op=01; EXECI if op=00 & I=1; EXECR if op=00 & I=0; BRANCH if op=10; FETCH if op=11 (illegal=1 in DECODE).
  - MEMADR → MEMREAD if L=1, else MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECR/EXECI → FETCH if cmd=1010 (CMP), else ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH → FETCH.
- Latency: LDR 5 cycles, STR 4, data-processing 4, CMP 3, B 3, illegal 2.
- Per-state outputs (unlisted outputs = 0):
  - FETCH: adr_src=0, ir_write=1, alu_src_a=1, alu_src_b=10, result_src=10, pc_write=1.
  - DECODE: alu_src_a=1, alu_src_b=10, result_src=10.
  - MEMADR: alu_src_a=0, alu_src_b=01; alu_control = ADD if U=1, SUB if U=0.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=cond_ex.
  - EXECR: alu_src_b=00, ALU decode.
  - EXECI: alu_src_b=01, ALU decode.
  - ALUWB: result_src=00, reg_write=1.
  - BRANCH: alu_src_a=0, alu_src_b=01, result_src=10, alu_control=ADD, pc_write=cond_ex.
- Default ALU op: alu_control = ADD in every state without an explicit decode.
- ALU decode by cmd: 0100→ADD(0), 0010→SUB(1), 1010→SUB(1), 0000→AND(2), 1100→ORR(3).
  - ALU_W=3 only: 0001→EOR(4), 1101→MOV(5).
  - Any other cmd is illegal: alu_control=ADD, flag_write=0, illegal=1 in the EXEC state, ALUWB writes suppressed.
- Flag writes (EXEC states only): flag_write[1]=S&cond_ex; flag_write[0]=S&cond_ex&(op is ADD/SUB/CMP). CMP flags are written regardless of the S bit.
- Condition gating: in MEMWB and ALUWB, write = cond_ex.
  - rd=15: reg_write=0 and pc_write=write, so the PC is loaded from the result.
  - otherwise: reg_write=write.
- imm_src and reg_src are combinational from op in all states.

Optional Feature:
- Macro: MC_RETIRE_CNT_EN.
- Defined:
  - Adds output instr_count[CNT_W-1:0], reset to 0.
  - Increments by 1 on the final cycle of every instruction: transition into FETCH from any non-FETCH state, excluding illegal paths.
  - Wraps modulo 2^CNT_W.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset held 2 cycles, then op=00 funct=101000 rd=2 cond_ex=1 → FETCH, DECODE, EXECI, ALUWB; alu_control=0 in EXECI; reg_write=1 only in ALUWB; pc_write=1 only in FETCH.
- LDR: op=01 funct=011001 rd=3 → 5-cycle sequence; alu_control=0 in MEMADR; adr_src=1 in MEMREAD; reg_write=1 in MEMWB. Same with funct=010001 (U=0) → alu_control=1 in MEMADR.
- SUBS with rd=15: op=00 funct=000101 cond_ex=1 → flag_write=11 in EXECR; ALUWB has pc_write=1 and reg_write=0.
- CMP with condition fail: op=00 funct=110101 cond_ex=0 → flag_write=00; 3 cycles then FETCH. Repeat with cond_ex=1 → flag_write=11.
- Illegal cases:
  - op=11 → illegal=1 in DECODE, back to FETCH next cycle.
  - ALU_W=2, funct=000010 (EOR) → illegal=1 in EXECR, no reg_write in ALUWB.
  - ALU_W=3, same funct → alu_control=4, normal write.
- Reset mid-instruction: reset=1 during MEMREAD → all enables 0 that cycle; FETCH on the first cycle after release. With MC_RETIRE_CNT_EN: count reads 0 after reset and 3 after three completed instructions.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute/writeback.
// Optional retired-instruction counter enabled by defining MC_RETIRE_CNT_EN.
module multicycle_ctrl #(
   parameter int unsigned ALU_W = 2,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       op,
   input  logic [5:0]       funct,
   input  logic [3:0]       rd,
   input  logic             cond_ex,
   output logic             pc_write,
   output logic             adr_src,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic [1:0]       result_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       imm_src,
   output logic [1:0]       reg_src,
   output logic [ALU_W-1:0] alu_control,
   output logic [1:0]       flag_write,
   output logic             illegal
`ifdef MC_RETIRE_CNT_EN
   ,
   output logic [CNT_W-1:0] instr_count
`endif
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_ORR = 3'd3;
   localparam logic [2:0] ALU_EOR = 3'd4;
   localparam logic [2:0] ALU_MOV = 3'd5;
   localparam logic       EXT_OPS = (ALU_W >= 3);

   if ((ALU_W < 2) || (ALU_W > 3) || (CNT_W < 1)) begin : g_param_check
      $error("multicycle_ctrl: unsupported ALU_W/CNT_W");
   end

   state_t state_q, state_d;

   logic       i_bit, s_bit, u_bit, l_bit;
   logic [3:0] cmd;
   logic       is_cmp, is_arith, alu_legal, s_eff, wr_en;
   logic [2:0] alu_dec;
   logic [2:0] alu_ctl;

   assign i_bit = funct[5];
   assign cmd   = funct[4:1];
   assign u_bit = funct[3];
   assign s_bit = funct[0];
   assign l_bit = funct[0];

   assign is_cmp   = (cmd == 4'b1010);
   assign is_arith = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
   assign s_eff    = s_bit | is_cmp;

   always_comb begin
      alu_legal = 1'b1;
      alu_dec   = ALU_ADD;
      unique case (cmd)
         4'b0100: alu_dec = ALU_ADD;
         4'b0010,
         4'b1010: alu_dec = ALU_SUB;
         4'b0000: alu_dec = ALU_AND;
         4'b1100: alu_dec = ALU_ORR;
         4'b0001: begin
            alu_legal = EXT_OPS;
            alu_dec   = EXT_OPS ? ALU_EOR : ALU_ADD;
         end
         4'b1101: begin
            alu_legal = EXT_OPS;
            alu_dec   = EXT_OPS ? ALU_MOV : ALU_ADD;
         end
         default: begin
            alu_legal = 1'b0;
            alu_dec   = ALU_ADD;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (reset) begin
         state_d = S_FETCH;
      end else begin
         unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
               unique case (op)
                  2'b00:   state_d = i_bit ? S_EXECI : S_EXECR;
                  2'b01:   state_d = S_MEMADR;
                  2'b10:   state_d = S_BRANCH;
                  default: state_d = S_FETCH;
               endcase
            end
            S_MEMADR:  state_d = l_bit ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:   state_d = is_cmp ? S_FETCH : S_ALUWB;
            default:   state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
   end

   // Writeback results go to the PC instead of the register file when rd is r15.
   always_comb begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctl    = ALU_ADD;
      flag_write = 2'b00;
      illegal    = 1'b0;
      wr_en      = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_write   = 1'b1;
         end
         S_DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            illegal    = (op == 2'b11);
         end
         S_MEMADR: begin
            alu_src_b = 2'b01;
            alu_ctl   = u_bit ? ALU_ADD : ALU_SUB;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            wr_en      = cond_ex;
            pc_write   = (rd == 4'd15) & wr_en;
            reg_write  = (rd != 4'd15) & wr_en;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = cond_ex;
         end
         S_EXECR,
         S_EXECI: begin
            alu_src_b     = (state_q == S_EXECI) ? 2'b01 : 2'b00;
            alu_ctl       = alu_legal ? alu_dec : ALU_ADD;
            flag_write[1] = s_eff & cond_ex & alu_legal;
            flag_write[0] = s_eff & cond_ex & alu_legal & is_arith;
            illegal       = ~alu_legal;
         end
         S_ALUWB: begin
            wr_en     = cond_ex & alu_legal;
            pc_write  = (rd == 4'd15) & wr_en;
            reg_write = (rd != 4'd15) & wr_en;
         end
         S_BRANCH: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_write   = cond_ex;
         end
         default: begin
            pc_write = 1'b0;
         end
      endcase
      if (reset) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         flag_write = 2'b00;
         illegal    = 1'b0;
      end
   end

   assign alu_control = ALU_W'(alu_ctl);
   assign imm_src     = op;
   assign reg_src     = {op == 2'b01, op == 2'b10};

`ifdef MC_RETIRE_CNT_EN
   logic [CNT_W-1:0] count_q, count_d;
   logic             retire;

   // Illegal paths (op=11 out of DECODE, bad cmd out of ALUWB) do not retire.
   assign retire = ~reset && (state_d == S_FETCH) && (state_q != S_FETCH) &&
                   (state_q != S_DECODE) && !((state_q == S_ALUWB) && !alu_legal);

   always_comb begin
      count_d = count_q;
      if (reset)
         count_d = '0;
      else if (retire)
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: ALU_W=2 and ALU_W=3 instances share stimulus.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       cond_ex;

   logic       pcw2, adr2, mw2, irw2, rw2, asa2, ill2;
   logic [1:0] rs2, asb2, imm2, rsrc2, fw2, alu2;
   logic       pcw3, adr3, mw3, irw3, rw3, asa3, ill3;
   logic [1:0] rs3, asb3, imm3, rsrc3, fw3;
   logic [2:0] alu3;
`ifdef MC_RETIRE_CNT_EN
   logic [31:0] cnt2, cnt3;
`endif

   multicycle_ctrl #(.ALU_W(2), .CNT_W(32)) dut2 (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond_ex(cond_ex),
      .pc_write(pcw2), .adr_src(adr2), .mem_write(mw2), .ir_write(irw2),
      .reg_write(rw2), .result_src(rs2), .alu_src_a(asa2), .alu_src_b(asb2),
      .imm_src(imm2), .reg_src(rsrc2), .alu_control(alu2), .flag_write(fw2),
      .illegal(ill2)
`ifdef MC_RETIRE_CNT_EN
      , .instr_count(cnt2)
`endif
   );

   multicycle_ctrl #(.ALU_W(3), .CNT_W(32)) dut3 (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond_ex(cond_ex),
      .pc_write(pcw3), .adr_src(adr3), .mem_write(mw3), .ir_write(irw3),
      .reg_write(rw3), .result_src(rs3), .alu_src_a(asa3), .alu_src_b(asb3),
      .imm_src(imm3), .reg_src(rsrc3), .alu_control(alu3), .flag_write(fw3),
      .illegal(ill3)
`ifdef MC_RETIRE_CNT_EN
      , .instr_count(cnt3)
`endif
   );

   always #5 clk = ~clk;

   // Enable bits inside a packed record: pc_write, mem_write, ir_write, reg_write, flag_write, illegal.
   localparam logic [19:0] EN_MASK = 20'hB8070;

   logic [19:0] obs2, obs3;
   assign obs2 = {pcw2, adr2, mw2, irw2, rw2, rs2, asa2, asb2, {1'b0, alu2}, fw2, ill2, imm2, rsrc2};
   assign obs3 = {pcw3, adr3, mw3, irw3, rw3, rs3, asa3, asb3, alu3, fw3, ill3, imm3, rsrc3};

   typedef struct {
      string       tag;
      logic [19:0] e2;
      logic [19:0] e3;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   exp_cnt2 = 0;
   int   exp_cnt3 = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] rec(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, input logic asa,
                                       input logic [1:0] asb, input logic [2:0] alu,
                                       input logic [1:0] fw, input logic ill,
                                       input logic [1:0] o);
      return {pcw, adr, mw, irw, rw, rs, asa, asb, alu, fw, ill, o, o == 2'b01, o == 2'b10};
   endfunction

   // {legal, code} from the command table for a given ALU width
   function automatic logic [3:0] tb_alu(input logic [3:0] c, input int w);
      case (c)
         4'b0100: return 4'b1_000;
         4'b0010: return 4'b1_001;
         4'b1010: return 4'b1_001;
         4'b0000: return 4'b1_010;
         4'b1100: return 4'b1_011;
         4'b0001: return (w == 3) ? 4'b1_100 : 4'b0_000;
         4'b1101: return (w == 3) ? 4'b1_101 : 4'b0_000;
         default: return 4'b0_000;
      endcase
   endfunction

   task automatic push(input string t, input logic [19:0] a, input logic [19:0] b);
      exp_t e;
      e.tag = t; e.e2 = a; e.e3 = b;
      sb.push_back(e);
   endtask

   // Pushes the expected cycle-by-cycle outputs; returns whether each width treats it as illegal.
   task automatic build(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                        input logic c, input string nm, output logic il2, output logic il3);
      logic [19:0] ex[2], wb[2];
      logic [3:0]  dec;
      logic        cmp, arith, s, f1, f0, w, lg[2];
      push({nm, ".fetch"}, rec(1,0,0,1,0,2'b10,1,2'b10,3'd0,2'b00,0,o),
                           rec(1,0,0,1,0,2'b10,1,2'b10,3'd0,2'b00,0,o));
      push({nm, ".decode"}, rec(0,0,0,0,0,2'b10,1,2'b10,3'd0,2'b00,o == 2'b11,o),
                            rec(0,0,0,0,0,2'b10,1,2'b10,3'd0,2'b00,o == 2'b11,o));
      il2 = (o == 2'b11);
      il3 = (o == 2'b11);
      case (o)
         2'b01: begin
            ex[0] = rec(0,0,0,0,0,2'b00,0,2'b01,f[3] ? 3'd0 : 3'd1,2'b00,0,o);
            push({nm, ".memadr"}, ex[0], ex[0]);
            if (f[0]) begin
               ex[0] = rec(0,1,0,0,0,2'b00,0,2'b00,3'd0,2'b00,0,o);
               push({nm, ".memread"}, ex[0], ex[0]);
               ex[0] = rec((r == 4'd15) & c,0,0,0,(r != 4'd15) & c,2'b01,0,2'b00,3'd0,2'b00,0,o);
               push({nm, ".memwb"}, ex[0], ex[0]);
            end else begin
               ex[0] = rec(0,1,c,0,0,2'b00,0,2'b00,3'd0,2'b00,0,o);
               push({nm, ".memwrite"}, ex[0], ex[0]);
            end
         end
         2'b00: begin
            cmp   = (f[4:1] == 4'b1010);
            arith = (f[4:1] == 4'b0100) || (f[4:1] == 4'b0010) || cmp;
            s     = f[0] | cmp;
            for (int k = 0; k < 2; k++) begin
               dec   = tb_alu(f[4:1], k + 2);
               lg[k] = dec[3];
               f1    = s & c & dec[3];
               f0    = f1 & arith;
               ex[k] = rec(0,0,0,0,0,2'b00,0,f[5] ? 2'b01 : 2'b00,dec[2:0],{f1, f0},~dec[3],o);
               w     = c & dec[3];
               wb[k] = rec((r == 4'd15) & w,0,0,0,(r != 4'd15) & w,2'b00,0,2'b00,3'd0,2'b00,0,o);
            end
            il2 = ~lg[0];
            il3 = ~lg[1];
            push({nm, ".exec"}, ex[0], ex[1]);
            if (!cmp) push({nm, ".aluwb"}, wb[0], wb[1]);
         end
         2'b10: begin
            ex[0] = rec(c,0,0,0,0,2'b10,0,2'b01,3'd0,2'b00,0,o);
            push({nm, ".branch"}, ex[0], ex[0]);
         end
         default: ;
      endcase
   endtask

   task automatic do_cycle;
      exp_t e;
      @(negedge clk);
      e = sb.pop_front();
      check_eq({e.tag, "/w2"}, {12'd0, obs2}, {12'd0, e.e2});
      check_eq({e.tag, "/w3"}, {12'd0, obs3}, {12'd0, e.e3});
      @(posedge clk);
      #1;
   endtask

   task automatic run_pending;
      int budget = 16;
      while (sb.size() > 0 && budget > 0) begin
         do_cycle();
         budget--;
      end
      check_eq("sb_drained", sb.size(), 0);
      sb.delete();
   endtask

   task automatic check_counts(input string nm);
`ifdef MC_RETIRE_CNT_EN
      check_eq({nm, ".cnt/w2"}, cnt2, exp_cnt2);
      check_eq({nm, ".cnt/w3"}, cnt3, exp_cnt3);
`endif
   endtask

   task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                            input logic c, input string nm);
      logic i2, i3;
      op = o; funct = f; rd = r; cond_ex = c;
      build(o, f, r, c, nm, i2, i3);
      run_pending();
      if (!i2) exp_cnt2++;
      if (!i3) exp_cnt3++;
      check_counts(nm);
   endtask

   // Runs the first n cycles of an instruction, then asserts reset for one cycle.
   task automatic reset_after(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                              input logic c, input int n, input string nm);
      logic i2, i3;
      exp_t tmp[$];
      exp_t e;
      op = o; funct = f; rd = r; cond_ex = c;
      build(o, f, r, c, nm, i2, i3);
      tmp = sb;
      sb.delete();
      for (int k = 0; k < n; k++) sb.push_back(tmp[k]);
      run_pending();
      reset = 1'b1;
      e = tmp[n];
      e.tag = {e.tag, "_rst"};
      e.e2 = e.e2 & ~EN_MASK;
      e.e3 = e.e3 & ~EN_MASK;
      sb.push_back(e);
      run_pending();
      reset = 1'b0;
      exp_cnt2 = 0;
      exp_cnt3 = 0;
      check_counts({nm, "_rst"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; op = 2'b00; funct = '0; rd = '0; cond_ex = 1'b0;
      @(posedge clk);
      #1;
      push("reset0", rec(1,0,0,1,0,2'b10,1,2'b10,3'd0,2'b00,0,2'b00) & ~EN_MASK,
                     rec(1,0,0,1,0,2'b10,1,2'b10,3'd0,2'b00,0,2'b00) & ~EN_MASK);
      push("reset1", rec(1,0,0,1,0,2'b10,1,2'b10,3'd0,2'b00,0,2'b00) & ~EN_MASK,
                     rec(1,0,0,1,0,2'b10,1,2'b10,3'd0,2'b00,0,2'b00) & ~EN_MASK);
      run_pending();
      reset = 1'b0;
      check_counts("after_reset");

      run_instr(2'b00, 6'b101000, 4'd2,  1'b1, "addi");
      run_instr(2'b01, 6'b011001, 4'd3,  1'b1, "ldr_u1");
      run_instr(2'b01, 6'b010001, 4'd3,  1'b1, "ldr_u0");
      run_instr(2'b01, 6'b011001, 4'd15, 1'b1, "ldr_pc");
      run_instr(2'b01, 6'b011001, 4'd5,  1'b0, "ldr_nc");
      run_instr(2'b01, 6'b011000, 4'd4,  1'b1, "str");
      run_instr(2'b01, 6'b010000, 4'd4,  1'b0, "str_nc");
      run_instr(2'b00, 6'b000101, 4'd15, 1'b1, "subs_pc");
      run_instr(2'b00, 6'b110101, 4'd0,  1'b0, "cmp_nc");
      run_instr(2'b00, 6'b110101, 4'd0,  1'b1, "cmp");
      run_instr(2'b00, 6'b010100, 4'd0,  1'b1, "cmp_s0");
      run_instr(2'b00, 6'b000001, 4'd6,  1'b1, "ands");
      run_instr(2'b00, 6'b111001, 4'd7,  1'b1, "orrs_i");
      run_instr(2'b00, 6'b001001, 4'd8,  1'b0, "adds_nc");
      run_instr(2'b10, 6'b100000, 4'd0,  1'b1, "b");
      run_instr(2'b10, 6'b100000, 4'd0,  1'b0, "b_nc");
      run_instr(2'b11, 6'b000000, 4'd1,  1'b1, "op11");
      run_instr(2'b00, 6'b000010, 4'd9,  1'b1, "eor");
      run_instr(2'b00, 6'b111011, 4'd10, 1'b1, "movs");
      run_instr(2'b00, 6'b001110, 4'd11, 1'b1, "bad_cmd");

      reset_after(2'b01, 6'b011001, 4'd3, 1'b1, 3, "ldr_mid");
      run_instr(2'b00, 6'b101000, 4'd2, 1'b1, "post_rst1");
      reset_after(2'b00, 6'b101000, 4'd2, 1'b1, 3, "alu_mid");
      run_instr(2'b00, 6'b101000, 4'd2, 1'b1, "post_rst2");
      run_instr(2'b01, 6'b011000, 4'd4, 1'b1, "post_rst3");
      run_instr(2'b10, 6'b100000, 4'd0, 1'b0, "post_rst4");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
